// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package adder_sched_pkg;

    // Scheduler phases: accept a request, pulse the adder, wait for its result, present the response.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Width of a requester index. Kept at least 1 so that index ports never collapse to zero width.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping modulo N.
// The owner of ptr decides when the pointer advances.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [id_w(N)-1:0]   ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [id_w(N)-1:0]   grant_idx
);

    localparam int IW = id_w(N);

    logic found;

    // Rotating priority search starting at ptr; the first valid requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[(int'(ptr) + k) % N]) begin
                found                         = 1'b1;
                grant[(int'(ptr) + k) % N]    = 1'b1;
                grant_idx                     = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one single-cycle adder among N requesters. Round-robin grant, one operation in flight,
// tagged response with valid/ready, and a watchdog that turns a missing adder valid into an error response.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic                 add_start,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W-1:0]         add_y,
    input  logic                 add_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [id_w(N)-1:0]   rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int IW = id_w(N);
    localparam int CW = $clog2(TIMEOUT);

    sched_state_e   state_q;
    sched_state_e   state_d;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant_idx;
    logic [CW-1:0]  wait_cnt;
    logic           accept;
    logic           timed_out;

    // req_ready is the only combinational output: it is the arbiter grant, enabled only in IDLE.
    rr_arbiter #(.N(N)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (state_q == IDLE),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    assign accept    = |req_ready;
    assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)                  state_d = ISSUE;
            ISSUE:                                state_d = WAIT;
            WAIT:    if (add_valid || timed_out)  state_d = RESP;
            RESP:    if (rsp_ready)               state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs: operand latch, start pulse, watchdog, response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            add_start <= 1'b0;
            busy      <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        add_a     <= req_a[int'(grant_idx) * W +: W];
                        add_b     <= req_b[int'(grant_idx) * W +: W];
                        rsp_id    <= grant_idx;
                        rr_ptr    <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                        add_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (add_valid) begin
                        rsp_sum   <= add_y;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (timed_out) begin
                        rsp_sum   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed scenarios plus a randomized phase,
// all responses scored against a queue-based reference model.
module tb_adder_rr_scheduler;
    import adder_sched_pkg::*;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a     = '0;
    logic [N*W-1:0]    req_b     = '0;
    logic              add_start;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_y     = '0;
    logic              add_valid = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_err;
    logic              busy;

    bit adder_on = 1'b1;
    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        bit           err;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   m_ptr = 0;
    int   m_g;
    exp_t m_e;

    adder_rr_scheduler #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_y     (add_y),
        .add_valid (add_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared one-cycle adder; adder_on = 0 models a dead adder that never answers.
    always @(posedge clk) begin
        add_valid <= add_start & adder_on;
        add_y     <= add_a + add_b;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic note_fail(input string tag);
        failures++;
        $display("FAIL %s: assertion violated at cycle %0d", tag, cyc_n);
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Reference model: round-robin grant from a pointer, sum modulo 2^W, error when the adder is dead.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ptr = 0;
        end else begin
            if (req_ready != '0) begin
                m_g = model_grant(req_valid, m_ptr);
                check("grant", 32'(req_ready), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
                if (m_g >= 0) begin
                    m_e.id  = m_g;
                    m_e.err = !adder_on;
                    m_e.sum = m_e.err ? '0 :
                              W'((int'(req_a[m_g*W +: W]) + int'(req_b[m_g*W +: W])) % (1 << W));
                    exp_q.push_back(m_e);
                    grant_log.push_back(m_g);
                    m_ptr = (m_g + 1) % N;
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(m_e.id));
                    check("rsp_sum", 32'(rsp_sum), 32'(m_e.sum));
                    check("rsp_err", 32'(rsp_err), 32'(m_e.err));
                end
            end
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready))
        else note_fail("a_onehot");
    a_start_pulse: assert property (@(posedge clk) disable iff (rst) add_start |=> !add_start)
        else note_fail("a_start_pulse");
    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        rsp_valid && !rsp_ready |=> $stable({rsp_id, rsp_sum, rsp_err}))
        else note_fail("a_rsp_stable");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one request, wait for its handshake (h = cycle of acceptance), then drop it.
    task automatic do_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, output int h);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
        h = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                h = cyc_n;
                break;
            end
        end
        check("hs_seen", 32'(h >= 0), 32'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int h;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [1:0]   s_id;
        logic [W-1:0] s_sum;
        logic         s_err;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_add_start", 32'(add_start), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        rst = 1'b0;
        tick();

        // Single request with latency profile.
        do_one(2, 16'h0100, 16'h0023, h);
        @(negedge clk);
        check("t2_start_at_1", 32'(add_start), 32'd1);
        check("t2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t2_start_pulse", 32'(add_start), 32'd0);
        check("t2_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t2_rsp_at_3", 32'(rsp_valid), 32'd1);
        check("t2_id", 32'(rsp_id), 32'd2);
        check("t2_sum", 32'(rsp_sum), 32'h0123);
        check("t2_err", 32'(rsp_err), 32'd0);
        drain();

        // Wrap-around sum.
        do_one(1, 16'hFFFF, 16'h0002, h);
        wait_rsp("t4_rsp_seen");
        check("t4_sum", 32'(rsp_sum), 32'h0001);
        check("t4_err", 32'(rsp_err), 32'd0);
        drain();

        // Response back-pressure; a waiting requester must not be granted until the handshake.
        rsp_ready = 1'b0;
        do_one(0, 16'($urandom), 16'($urandom), h);
        req_b[3*W +: W] = 16'($urandom);
        req_a[3*W +: W] = 16'($urandom);
        req_valid[3]    = 1'b1;
        wait_rsp("t5_rsp_seen");
        s_id  = rsp_id;
        s_sum = rsp_sum;
        s_err = rsp_err;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_valid_held", 32'(rsp_valid), 32'd1);
            check("t5_stable", 32'({rsp_id, rsp_sum, rsp_err}), 32'({s_id, s_sum, s_err}));
            check("t5_no_grant", 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_next_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        drain();

        // Dead adder: watchdog error after TIMEOUT WAIT cycles, then normal service.
        adder_on = 1'b0;
        do_one($urandom_range(0, N - 1), 16'($urandom), 16'($urandom), h);
        for (int k = 0; k < 1 + TIMEOUT; k++) begin
            @(negedge clk);
            check("t6_no_rsp_yet", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        check("t6_rsp", 32'(rsp_valid), 32'd1);
        check("t6_err", 32'(rsp_err), 32'd1);
        check("t6_sum_zero", 32'(rsp_sum), 32'd0);
        drain();
        adder_on = 1'b1;
        do_one($urandom_range(0, N - 1), 16'($urandom), 16'($urandom), h);
        wait_rsp("t6_recover_rsp");
        check("t6_recover_err", 32'(rsp_err), 32'd0);
        drain();

        // Reset during WAIT drops the operation and restarts the pointer at 0.
        adder_on = 1'b0;
        do_one(1, 16'($urandom), 16'($urandom), h);
        @(negedge clk);
        @(negedge clk);
        check("t1_in_wait_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t1_rst_busy", 32'(busy), 32'd0);
        check("t1_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_rst_add_start", 32'(add_start), 32'd0);
        @(posedge clk);
        tick();
        rst      = 1'b0;
        adder_on = 1'b1;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_valid = 4'b0101;
        h = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                h = 0;
                break;
            end
        end
        check("t1_first_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[2]) break;
        end
        check("t1_second_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        drain();

        // All requesters held valid: strict rotation from a fresh pointer.
        pulse_reset();
        grant_log.delete();
        req_valid = '1;
        for (int k = 0; k < 60; k++) begin
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            tick();
            if (grant_log.size() >= 5) break;
        end
        req_valid = '0;
        check("t3_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++)
            check($sformatf("t3_grant%0d", k),
                  32'((k < grant_log.size()) ? grant_log[k] : -1), 32'(exp_order[k]));
        drain();

        // Randomized traffic with random back-pressure, scored by the model.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
